ddr4_mrs_receiver: RTL
======================

Name: ddr4_mrs_receiver

Overview:
- DRAM-side counterpart of the controller initialization sequencer.
- Watches the DDR4 command bus during power-up and decodes MRS writes into shadow mode registers MR0–MR6.
- Checks tXPR/tMRD/tMOD/tZQinit spacing and the ZQCL handshake, then raises init_done.
- Used by the device model and as a protocol checker under the memory-model side of the testbench.

Parameters:
- T_XPR, 72, minimum cycles from CKE rise to first MRS.
- T_MRD, 8, minimum cycles between two MRS commands.
- T_MOD, 24, minimum cycles from last MRS to ZQCL.
- T_ZQINIT, 512, cycles from ZQCL to init_done.
- CNT_W, 11, width of the saturating interval counters; must satisfy 2^CNT_W > max(T_*).

Ports:
- clock_t  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cke  in  1  clock enable from controller.
- cs_n  in  1  chip select, active low.
- act_n  in  1  activate, active low.
- ras_n  in  1  RAS/A16.
- cas_n  in  1  CAS/A15.
- we_n  in  1  WE/A14.
- bg  in  2  bank group.
- ba  in  2  bank address.
- addr  in  14  A13..A0.
- mr_rd_sel  in  3  shadow register read select.
- mr_rd_data  out  14  combinational read of MR[mr_rd_sel]; 0 for sel 7.
- cas_lat  out  5  MR0 {A6,A5,A4,A2} + 9.
- cwl  out  5  MR2 A5:A3 + 9.
- al_sel  out  2  MR1 A4:A3.
- dll_en  out  1  MR1 A0.
- burst_len  out  2  MR0 A1:A0.
- rd_pre  out  1  MR4 A11.
- wr_pre  out  1  MR4 A12.
- tccd_l  out  4  MR6 A12:A10 + 4.
- init_done  out  1  initialization complete.
- err  out  5  sticky violation flags.

Behaviour:
- Command decode, qualified by cke=1 and cs_n=0:
  - MRS: act_n=1, ras_n=0, cas_n=0, we_n=0. Target index = {bg[0], ba}; index 7 is ignored and sets err[3].
  - ZQCL: act_n=1, ras_n=1, cas_n=1, we_n=0, addr[10]=1.
  - Everything else, including cs_n=1 (DES), is a non-event.
- Reset: MR0–MR6 = 0, mr_written = 7'b0, err = 0, init_done = 0, state IDLE, counters 0. Derived outputs reflect the zeroed registers (cas_lat=9, cwl=9, tccd_l=4).
- Interval counters:
  - since_cke, since_mrs and zq_cnt saturate at all-ones and never wrap.
  - since_mrs resets to 1 on the cycle after each MRS.
- FSM states: IDLE, XPR, CFG, ZQ, READY.
  - IDLE: waits for cke=1, then → XPR with since_cke cleared. Any command seen in IDLE is ignored.
  - XPR: an MRS with since_cke < T_XPR sets err[0]. Any MRS (legal or not) is still written and moves to CFG.
  - CFG:
    - Each MRS writes MR[idx] <= addr and sets mr_written[idx].
    - A spacing below T_MRD sets err[1]; the write still happens.
    - ZQCL with mr_written != 7'h7F sets err[3] and the state stays CFG.
    - ZQCL with since_mrs < T_MOD sets err[2] but still goes → ZQ.
    - A legal ZQCL goes → ZQ with zq_cnt = 0.
  - ZQ: zq_cnt increments each cycle. When zq_cnt == T_ZQINIT-1, go → READY with init_done=1 on the next edge. Any MRS/ZQCL in ZQ sets err[3] and does not write.
  - READY: MRS is accepted, updates the register and enforces T_MRD. init_done stays 1.
- cke falling in any non-IDLE state → IDLE next cycle, with init_done=0 and mr_written cleared. MR contents and err are retained.
- Simultaneous reset and any command: reset wins.
- Derived outputs are registered from the MR shadows with no extra latency: they are valid the cycle after the MRS edge.
- err bits are sticky until reset.

Optional Feature:
- Macro MRS_ORDER_CHECK_EN.
- When defined, the first write of each MR during CFG must follow the sequence MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  - An out-of-order first write sets err[4]; the register is still written.
  - Rewrites of an already-written MR are exempt.
- When not defined, err[4] is tied to 0 and there is no order-tracking logic.

Test Plan:
1. Nominal: reset 2 cycles; cke=1; 72 DES; MR3,6,5,4,2,1,0 spaced 9 cycles, with MR0 addr=14'h0034 (A6:A4=011, A2=1, BL=00); 24 DES; ZQCL; 512 DES → cas_lat=16, burst_len=0, init_done=1 exactly 512 cycles after ZQCL, err=0.
2. Two MRS 4 cycles apart in CFG → err[1]=1 the next cycle; second MR value is readable on mr_rd_data.
3. ZQCL 10 cycles after MR0 with all MRs written → err[2]=1, state ZQ, init_done still rises after 512 cycles.
4. ZQCL issued before MR5 written → err[3]=1, no ZQ entry, init_done stays 0; completing MR5 then ZQCL proceeds normally.
5. cke dropped mid-CFG after MR3/MR6 → IDLE, mr_written=0, err unchanged; reassert cke and the full sequence succeeds.
6. MR6 written before MR3 → err[4]=1 with MRS_ORDER_CHECK_EN, err[4]=0 without it; MR6 register is updated in both builds.

Source files
------------

// File: rtl/ddr4_mrs_receiver.sv
// ---------------------------------------------------------------------------
// ddr4_mrs_receiver
//
// DRAM-side view of DDR4 power-up initialization. The block watches the
// command bus, decodes MRS writes into shadow registers MR0..MR6, and checks
// command spacing: tXPR (CKE rise to first MRS), tMRD (MRS to MRS), tMOD
// (last MRS to ZQCL) and tZQinit (ZQCL to ready). When the ZQ calibration
// window has elapsed it raises init_done.
//
// Optional build macro: MRS_ORDER_CHECK_EN
//   When defined, the first write of each MR during bring-up must follow
//   MR3, MR6, MR5, MR4, MR2, MR1, MR0. An out-of-order first write sets
//   err[4]; the register is still written. When undefined, err[4] is 0.
//
// Ports
//   clock_t     : clock, rising edge
//   reset       : synchronous, active-high
//   cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, addr : DDR4 command bus
//   mr_rd_sel   : shadow register read select
//   mr_rd_data  : MR[mr_rd_sel], 0 for select 7 (combinational)
//   cas_lat, cwl, al_sel, dll_en, burst_len, rd_pre, wr_pre, tccd_l :
//                 fields decoded from the MR shadows
//   init_done   : initialization complete
//   err         : sticky flags [0] tXPR, [1] tMRD, [2] tMOD,
//                 [3] illegal command/index, [4] MR write order
//   fsm_state   : current sequencer state (debug)
// ---------------------------------------------------------------------------
module ddr4_mrs_receiver #(
  parameter int T_XPR    = 72,
  parameter int T_MRD    = 8,
  parameter int T_MOD    = 24,
  parameter int T_ZQINIT = 512,
  parameter int CNT_W    = 11
) (
  input  logic        clock_t,
  input  logic        reset,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  bg,
  input  logic [1:0]  ba,
  input  logic [13:0] addr,
  input  logic [2:0]  mr_rd_sel,
  output logic [13:0] mr_rd_data,
  output logic [4:0]  cas_lat,
  output logic [4:0]  cwl,
  output logic [1:0]  al_sel,
  output logic        dll_en,
  output logic [1:0]  burst_len,
  output logic        rd_pre,
  output logic        wr_pre,
  output logic [3:0]  tccd_l,
  output logic        init_done,
  output logic [4:0]  err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XPR   = 3'd1,
    S_CFG   = 3'd2,
    S_ZQ    = 3'd3,
    S_READY = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] XPR_MIN = CNT_W'(T_XPR);
  localparam logic [CNT_W-1:0] MRD_MIN = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] MOD_MIN = CNT_W'(T_MOD);
  localparam logic [CNT_W-1:0] ZQ_LAST = CNT_W'(T_ZQINIT - 1);

  state_t            state, next_state;
  logic [13:0]       mr [7];
  logic [6:0]        mr_written;
  logic [CNT_W-1:0]  since_cke, since_mrs, zq_cnt;

  logic              mrs_cmd, zqcl_cmd, idx_bad;
  logic [2:0]        idx;
  logic              mr_we, mrs_take, zq_start, drop;
  logic [4:0]        err_set;
  logic              unused_bits;

  // Only bg[0] takes part in the MR index.
  assign unused_bits = bg[1];

  assign mrs_cmd  = cke && !cs_n && act_n && !ras_n && !cas_n && !we_n;
  assign zqcl_cmd = cke && !cs_n && act_n && ras_n && cas_n && !we_n && addr[10];
  assign idx      = {bg[0], ba};
  assign idx_bad  = (idx == 3'd7);

`ifdef MRS_ORDER_CHECK_EN
  // pred_mask: MRs that must already be written before the first write of
  // MR[idx] (bit i = MRi). Sequence MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  logic [6:0] pred_mask;
  logic [7:0] written_ext;
  logic       order_bad;

  assign written_ext = {1'b1, mr_written};

  always_comb begin
    pred_mask = 7'h00;
    case (idx)
      3'd3:    pred_mask = 7'h00;
      3'd6:    pred_mask = 7'h08;
      3'd5:    pred_mask = 7'h48;
      3'd4:    pred_mask = 7'h68;
      3'd2:    pred_mask = 7'h78;
      3'd1:    pred_mask = 7'h7C;
      3'd0:    pred_mask = 7'h7E;
      default: pred_mask = 7'h00;
    endcase
  end

  // Rewrites of an already-written MR are exempt.
  assign order_bad = !written_ext[idx] && |(pred_mask & ~mr_written);
`endif

  always_ff @(posedge clock_t) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mr_we      = 1'b0;
    mrs_take   = 1'b0;
    zq_start   = 1'b0;
    drop       = 1'b0;
    err_set    = 5'b0;
    if (state != S_IDLE && !cke) begin
      next_state = S_IDLE;
      drop       = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cke) next_state = S_XPR;
        end
        S_XPR: begin
          if (mrs_cmd) begin
            mrs_take   = 1'b1;
            next_state = S_CFG;
            if (since_cke < XPR_MIN) err_set[0] = 1'b1;
            if (idx_bad) err_set[3] = 1'b1;
            else begin
              mr_we = 1'b1;
`ifdef MRS_ORDER_CHECK_EN
              err_set[4] = order_bad;
`endif
            end
          end
        end
        S_CFG: begin
          if (mrs_cmd) begin
            mrs_take = 1'b1;
            if (since_mrs < MRD_MIN) err_set[1] = 1'b1;
            if (idx_bad) err_set[3] = 1'b1;
            else begin
              mr_we = 1'b1;
`ifdef MRS_ORDER_CHECK_EN
              err_set[4] = order_bad;
`endif
            end
          end else if (zqcl_cmd) begin
            if (mr_written != 7'h7F) err_set[3] = 1'b1;
            else begin
              if (since_mrs < MOD_MIN) err_set[2] = 1'b1;
              next_state = S_ZQ;
              zq_start   = 1'b1;
            end
          end
        end
        S_ZQ: begin
          if (mrs_cmd || zqcl_cmd) err_set[3] = 1'b1;
          if (zq_cnt == ZQ_LAST) next_state = S_READY;
        end
        S_READY: begin
          if (mrs_cmd) begin
            mrs_take = 1'b1;
            if (since_mrs < MRD_MIN) err_set[1] = 1'b1;
            if (idx_bad) err_set[3] = 1'b1;
            else         mr_we = 1'b1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) mr[i] <= 14'h0;
      mr_written <= 7'h0;
      err        <= 5'h0;
      init_done  <= 1'b0;
      since_cke  <= '0;
      since_mrs  <= '0;
      zq_cnt     <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (mr_we && idx == 3'(i)) mr[i] <= addr;
      end
      if (drop)       mr_written <= 7'h0;
      else if (mr_we) mr_written <= mr_written | (7'h01 << idx);
      err       <= err | err_set;
      init_done <= (next_state == S_READY);

      // The CKE-rise edge counts as the first elapsed cycle, so since_cke
      // reads as the edge distance from the rise, like since_mrs does.
      if (state == S_IDLE)       since_cke <= cke ? CNT_W'(1) : '0;
      else if (since_cke != '1)  since_cke <= since_cke + CNT_W'(1);

      if (mrs_take)              since_mrs <= CNT_W'(1);
      else if (since_mrs != '1)  since_mrs <= since_mrs + CNT_W'(1);

      if (zq_start)                               zq_cnt <= '0;
      else if (state == S_ZQ && zq_cnt != '1)     zq_cnt <= zq_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mr_rd_data = 14'h0;
    for (int i = 0; i < 7; i++) begin
      if (mr_rd_sel == 3'(i)) mr_rd_data = mr[i];
    end
  end

  // Field decodes straight off the shadow registers: valid the cycle after
  // the MRS edge.
  assign cas_lat   = 5'({mr[0][6:4], mr[0][2]}) + 5'd9;
  assign cwl       = 5'(mr[2][5:3]) + 5'd9;
  assign al_sel    = mr[1][4:3];
  assign dll_en    = mr[1][0];
  assign burst_len = mr[0][1:0];
  assign rd_pre    = mr[4][11];
  assign wr_pre    = mr[4][12];
  assign tccd_l    = 4'(mr[6][12:10]) + 4'd4;
  assign fsm_state = state;

endmodule
